// File: rtl/ebi_pkg.sv
// Shared types and header-field helpers for the EBI multi-channel transmitter.
package ebi_pkg;

    // Frame sequencer states: what the bus is presenting in the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } ebi_state_e;

    // Storage width of one entry in the per-channel beat-count parameter.
    localparam int BEATS_PW   = 8;
    // Header: channel id sits at the bottom, beat count directly above it.
    localparam int HDR_ID_LSB = 0;

    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_beats(input int msg_wd, input int bus_wd);
        return (msg_wd + bus_wd - 1) / bus_wd;
    endfunction

    function automatic int hdr_cnt_w(input int mb);
        return $clog2(mb + 1);
    endfunction

    function automatic int hdr_cnt_lsb(input int n);
        return HDR_ID_LSB + ch_id_w(n);
    endfunction

endpackage

// File: rtl/ebi_rr_arb.sv
// Round-robin picker: first requester at or after ptr, wrapping around.
module ebi_rr_arb
    import ebi_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = ch_id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    // Scan N positions starting at ptr; first hit wins.
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ebi_mc_tx.sv
// Multi-channel credit-gated transmitter: header beat then LSB-first payload beats.
module ebi_mc_tx
    import ebi_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int BUS_WD      = 32,
    parameter int MSG_WD      = 128,
    parameter int CREDIT_MAX  = 4,
    parameter logic [CHANNEL_NUM-1:0][BEATS_PW-1:0] CH_BEATS =
        {CHANNEL_NUM{BEATS_PW'(max_beats(MSG_WD, BUS_WD))}}
) (
    input  logic                                bus_clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUM-1:0]              ch_valid_i,
    input  logic [CHANNEL_NUM-1:0][MSG_WD-1:0]  ch_data_i,
    output logic [CHANNEL_NUM-1:0]              ch_ready_o,
    output logic [BUS_WD-1:0]                   bus_o,
    output logic                                bus_valid_o,
    input  logic                                credit_ret_v_i,
    input  logic [ch_id_w(CHANNEL_NUM)-1:0]     credit_ret_id_i,
    output logic                                credit_err_o,
    output logic                                idle_o
);

    localparam int CH_ID_W   = ch_id_w(CHANNEL_NUM);
    localparam int MAX_BEATS = max_beats(MSG_WD, BUS_WD);
    localparam int CNT_W     = hdr_cnt_w(MAX_BEATS);
    localparam int CNT_LSB   = hdr_cnt_lsb(CHANNEL_NUM);
    localparam int PAD_W     = MAX_BEATS * BUS_WD;
    localparam int CR_W      = $clog2(CREDIT_MAX + 1);

    ebi_state_e             state, state_nxt;
    logic [CH_ID_W-1:0]     rr_ptr, cur_id, gnt_id;
    logic [CNT_W-1:0]       cur_beats, beat_idx;
    logic [PAD_W-1:0]       data_q;
    logic [CR_W-1:0]        credit [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0] elig, gnt, ret_hit, ovf;
    logic                   gnt_any, last_beat, accept, ret_ok;

    // A channel may compete only with a pending message and at least one credit.
    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            elig[i] = ch_valid_i[i] && (credit[i] != '0);
        end
    end

    ebi_rr_arb #(.N(CHANNEL_NUM), .ID_W(CH_ID_W)) u_arb (
        .req    (elig),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    // Accept only when the bus is free next cycle; never while reset is held.
    assign last_beat  = (state == ST_DATA) && (beat_idx == cur_beats - 1'b1);
    assign accept     = rst && gnt_any && ((state == ST_IDLE) || last_beat);
    assign ch_ready_o = accept ? gnt : '0;
    assign idle_o     = (state == ST_IDLE);

    // Out-of-range return ids are dropped but flagged.
    assign ret_ok = credit_ret_v_i && (int'(credit_ret_id_i) < CHANNEL_NUM);

    // Per-channel return decode and overflow detection (a same-cycle accept cancels the return).
    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            ret_hit[i] = ret_ok && (credit_ret_id_i == CH_ID_W'(i));
            ovf[i]     = ret_hit[i] && !ch_ready_o[i] && (credit[i] == CR_W'(CREDIT_MAX));
        end
    end

    // State register.
    always_ff @(posedge bus_clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state and bus drive; bus is zero whenever no frame beat is presented.
    always_comb begin
        state_nxt   = state;
        bus_o       = '0;
        bus_valid_o = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                state_nxt   = ST_DATA;
                bus_valid_o = 1'b1;
                bus_o[HDR_ID_LSB +: CH_ID_W] = cur_id;
                bus_o[CNT_LSB +: CNT_W]      = cur_beats;
            end
            ST_DATA: begin
                if (last_beat) state_nxt = accept ? ST_HDR : ST_IDLE;
                bus_valid_o = 1'b1;
                bus_o       = data_q[int'(beat_idx) * BUS_WD +: BUS_WD];
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame capture, beat counter and round-robin pointer.
    always_ff @(posedge bus_clk) begin
        if (!rst) begin
            rr_ptr    <= '0;
            cur_id    <= '0;
            cur_beats <= '0;
            beat_idx  <= '0;
            data_q    <= '0;
        end else if (accept) begin
            cur_id    <= gnt_id;
            cur_beats <= CNT_W'(CH_BEATS[gnt_id]);
            data_q    <= PAD_W'(ch_data_i[gnt_id]);
            beat_idx  <= '0;
            rr_ptr    <= (int'(gnt_id) == CHANNEL_NUM - 1) ? '0 : gnt_id + 1'b1;
        end else if (state == ST_DATA) begin
            beat_idx  <= beat_idx + 1'b1;
        end
    end

    // Credit counters: accept consumes, return refunds (saturating), both together cancel.
    always_ff @(posedge bus_clk) begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (!rst) begin
                credit[i] <= CR_W'(CREDIT_MAX);
            end else if (ret_hit[i] && !ch_ready_o[i]) begin
                if (credit[i] != CR_W'(CREDIT_MAX)) credit[i] <= credit[i] + 1'b1;
            end else if (ch_ready_o[i] && !ret_hit[i]) begin
                credit[i] <= credit[i] - 1'b1;
            end
        end
    end

    // Sticky error on overflow or bad return id.
    always_ff @(posedge bus_clk) begin
        if (!rst) credit_err_o <= 1'b0;
        else      credit_err_o <= credit_err_o | (credit_ret_v_i && !ret_ok) | (|ovf);
    end

endmodule

// File: doc/ebi_mc_tx.md
EBI_MC_TX -- requirements
Module: ebi_mc_tx

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 4, number of independent TX channels (2..16).
REQ-002 SHALL have parameter BUS_WD, default 32, off-die bus width in bits.
REQ-003 SHALL have parameter MSG_WD, default 128, maximum message width; MAX_BEATS = ceil(MSG_WD/BUS_WD).
REQ-004 SHALL have parameter CREDIT_MAX, default 4, initial and maximum credits per channel.
REQ-005 SHALL have parameter CH_BEATS, default all MAX_BEATS, per-channel payload beat count, each value in 1..MAX_BEATS.
REQ-006 SHALL have port bus_clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-008 SHALL have port ch_valid_i, input, CHANNEL_NUM, per-channel message valid.
REQ-009 SHALL have port ch_data_i, input, CHANNEL_NUM x MSG_WD, per-channel message payload.
REQ-010 SHALL have port ch_ready_o, output, CHANNEL_NUM, per-channel accept pulse.
REQ-011 SHALL have port bus_o, output, BUS_WD, serialized beat.
REQ-012 SHALL have port bus_valid_o, output, 1, beat valid.
REQ-013 SHALL have port credit_ret_v_i, input, 1, credit return strobe.
REQ-014 SHALL have port credit_ret_id_i, input, CH_ID_W = clog2(CHANNEL_NUM), returning channel.
REQ-015 SHALL have port credit_err_o, output, 1, sticky credit-overflow flag.
REQ-016 SHALL have port idle_o, output, 1, high when FSM is in IDLE with no frame in flight.

Function
REQ-017 SHALL implement FSM IDLE -> HDR -> DATA -> (IDLE | HDR).
REQ-018 A channel SHALL be eligible when ch_valid_i[i]=1 and credit[i]>0.
REQ-019 SHALL grant one eligible channel per accept via round-robin, starting from rr_ptr; after a grant, rr_ptr = grant+1 mod CHANNEL_NUM.
REQ-020 Accept SHALL be allowed in IDLE, or in DATA on the last beat (back-to-back); ch_ready_o[g] SHALL pulse for exactly that cycle, and the payload SHALL be latched.
REQ-021 A message accepted in cycle T SHALL produce the header on bus_o in T+1, and payload beats in T+2 .. T+1+CH_BEATS[g], with bus_valid_o=1 for every beat.
REQ-022 Header layout: bits [CH_ID_W-1:0] = channel id, next clog2(MAX_BEATS+1) bits = CH_BEATS[g], remaining bits 0.
REQ-023 Payload beats SHALL be sent LSB-first: beat k = latched data[k*BUS_WD +: BUS_WD]; the last beat SHALL be zero-padded above MSG_WD.
REQ-024 Outside frame beats, bus_valid_o SHALL be 0 and bus_o SHALL be 0.
REQ-025 credit[g] SHALL decrement on accept; credit[id] SHALL increment on credit_ret_v_i.
REQ-026 If accept and return hit the same channel in the same cycle, credit SHALL be unchanged.
REQ-027 A return at credit=CREDIT_MAX SHALL saturate the count and set credit_err_o.
REQ-028 credit_ret_id_i >= CHANNEL_NUM SHALL be ignored and SHALL also set credit_err_o.
REQ-029 A channel with credit=0 SHALL never be granted, and its ch_ready_o SHALL stay 0.
REQ-030 ch_data_i changes after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-031 While rst=0 at a bus_clk edge, the block SHALL set: state IDLE, rr_ptr 0, all credits CREDIT_MAX, bus_o 0, bus_valid_o 0, ch_ready_o 0, credit_err_o 0, idle_o 1.
REQ-032 Reset mid-frame SHALL abandon the frame; bus_valid_o SHALL be 0 from the cycle after the reset edge, and no partial beat SHALL resume.

Structure
REQ-033 FSM state enum, header field widths/offsets and the CH_ID_W helper SHALL live in shared package ebi_pkg.
REQ-034 Round-robin selection SHALL be a sub-module ebi_rr_arb (req, ptr in; one-hot grant, grant id, any out); credits, FSM and serializer SHALL stay in ebi_mc_tx.

Verification
REQ-035 Single message test: CHANNEL_NUM=4, BUS_WD=32, MSG_WD=128; ch0 sends 0x44443333_22221111_... in T. Required: header 0x10 (id 0, beats 4) in T+1; 0x...1111 through to the top beat in T+2..T+5; idle_o=1 in T+6.
REQ-036 Round-robin test: all four channels valid continuously. Required: grants 0,1,2,3,0 back-to-back with no idle cycle between frames.
REQ-037 Credit exhaustion test: CREDIT_MAX=2, ch1 always valid, no returns. Required: exactly 2 frames; ch_ready_o[1] stays 0 afterwards; one return on id 1 produces a third frame.
REQ-038 Simultaneous event test: accept on ch2 in the same cycle as credit_ret_v_i with id 2. Required: credit[2] unchanged.
REQ-039 Overflow test: return on id 3 at full credit, then return on id 7. Required: credit_err_o=1 and sticky; credits stay at CREDIT_MAX.
REQ-040 Reset mid-frame test: assert rst=0 during beat 2 of a frame. Required: bus_valid_o=0 on the next cycle; all credits restored; a fresh frame works correctly after release.
